// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU with a valid/ready handshake and an iterative shift-add multiplier.
// Optional unsigned restoring divider (DIVU, funct 001001) is enabled by defining SEQ_ALU_DIV_EN.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] Oper2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Alu_ans,
    output logic             Zflag,
    output logic             illegal,
    output logic             busy
);

`ifdef SEQ_ALU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLTU, OP_SLT,
        OP_SLL, OP_SRL, OP_MUL, OP_DIV, OP_ILL
    } op_t;

    state_t           state_reg, state_next;
    op_t              op_kind;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
    logic [SHW-1:0]   cnt_reg;
    logic             cnt_last;
    logic [WIDTH-1:0] ans_reg;
    logic             zflag_reg, illegal_reg;
    logic [WIDTH-1:0] mul_acc_next;
    logic             accept;

    // Opcode / funct decode
    always_comb begin
        op_kind = OP_ILL;
        case (OpCode)
            6'b000000, 6'b000001: op_kind = OP_ADD;
            6'b000011:            op_kind = OP_SUB;
            6'b000010: begin
                case (funct)
                    6'b000000: op_kind = OP_ADD;
                    6'b000001: op_kind = OP_SUB;
                    6'b000010: op_kind = OP_AND;
                    6'b000011: op_kind = OP_OR;
                    6'b000100: op_kind = OP_SLTU;
                    6'b000101: op_kind = OP_SLT;
                    6'b000110: op_kind = OP_SLL;
                    6'b000111: op_kind = OP_SRL;
                    6'b001000: op_kind = OP_MUL;
`ifdef SEQ_ALU_DIV_EN
                    6'b001001: op_kind = OP_DIV;
`endif
                    default:   op_kind = OP_ILL;
                endcase
            end
            default: op_kind = OP_ILL;
        endcase
    end

    // Logarithmic barrel shifters; stage gi shifts by 2**gi when Oper2[gi] is set
    logic [WIDTH-1:0] sll_stage [0:SHW];
    logic [WIDTH-1:0] srl_stage [0:SHW];

    assign sll_stage[0] = rs_in;
    assign srl_stage[0] = rs_in;

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_shift
            assign sll_stage[gi+1] = Oper2[gi] ? (sll_stage[gi] << (2**gi)) : sll_stage[gi];
            assign srl_stage[gi+1] = Oper2[gi] ? (srl_stage[gi] >> (2**gi)) : srl_stage[gi];
        end
    endgenerate

    always_comb begin
        alu_result = '0;
        case (op_kind)
            OP_ADD:  alu_result = rs_in + Oper2;
            OP_SUB:  alu_result = rs_in - Oper2;
            OP_AND:  alu_result = rs_in & Oper2;
            OP_OR:   alu_result = rs_in | Oper2;
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (rs_in < Oper2)};
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(rs_in) < $signed(Oper2))};
            OP_SLL:  alu_result = sll_stage[SHW];
            OP_SRL:  alu_result = srl_stage[SHW];
            default: alu_result = '0;
        endcase
    end

    // Shift-add step: a_reg is the multiplicand moving left, b_reg the multiplier moving right
    assign mul_acc_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    assign cnt_last     = (cnt_reg == SHW'(WIDTH - 1));

`ifdef SEQ_ALU_DIV_EN
    // Restoring divide: acc_reg is the partial remainder, b_reg shifts the dividend out and the quotient in
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] div_rem_next, div_q_next;

    assign rem_shift    = {acc_reg, b_reg[WIDTH-1]};
    assign rem_ge       = (rem_shift >= {1'b0, a_reg});
    assign rem_diff     = rem_shift[WIDTH-1:0] - a_reg;
    assign div_rem_next = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
    assign div_q_next   = {b_reg[WIDTH-2:0], rem_ge};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (op_kind == OP_MUL) begin
                        state_next = MUL;
                    end
`ifdef SEQ_ALU_DIV_EN
                    else if (op_kind == OP_DIV) begin
                        state_next = DIV;
                    end
`endif
                    else begin
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (cnt_last) state_next = DONE;
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
                if (cnt_last) state_next = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath registers; DONE leaves everything untouched so the result holds under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ans_reg     <= '0;
            zflag_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg <= '0;
                        acc_reg <= '0;
                        if (op_kind == OP_MUL) begin
                            a_reg <= rs_in;
                            b_reg <= Oper2;
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (op_kind == OP_DIV) begin
                            a_reg <= Oper2;
                            b_reg <= rs_in;
                        end
`endif
                        else begin
                            ans_reg     <= alu_result;
                            zflag_reg   <= (op_kind != OP_ILL) && (alu_result == '0);
                            illegal_reg <= (op_kind == OP_ILL);
                        end
                    end
                end
                MUL: begin
                    acc_reg <= mul_acc_next;
                    a_reg   <= a_reg << 1;
                    b_reg   <= b_reg >> 1;
                    cnt_reg <= cnt_reg + SHW'(1);
                    if (cnt_last) begin
                        ans_reg     <= mul_acc_next;
                        zflag_reg   <= (mul_acc_next == '0);
                        illegal_reg <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV: begin
                    acc_reg <= div_rem_next;
                    b_reg   <= div_q_next;
                    cnt_reg <= cnt_reg + SHW'(1);
                    if (cnt_last) begin
                        ans_reg     <= div_q_next;
                        zflag_reg   <= (div_q_next == '0);
                        illegal_reg <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign Alu_ans = ans_reg;
    assign Zflag   = zflag_reg;
    assign illegal = illegal_reg;

endmodule
